// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// Execute-issue stage in front of the RISC-V ALU. It captures decoded
// operations from decode and resolves operand hazards by forwarding from the
// MEM and WB stages. It presents registered Ctrl/SrcA/SrcB to the ALU through
// a valid/ready handshake. A two-entry arrangement (main + skid) keeps full
// throughput while in_ready stays a plain register output.
//
// Configuration macro: ALU_ISSUE_FWD_EN
//   defined   : operands are forwarded at capture and snooped while held
//   undefined : register-file values are captured as-is (x0 still reads 0),
//               and the MEM/WB inputs are ignored
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   flush                drop every held operation (branch redirect)
//   in_valid / in_ready  decode-side handshake (in_ready is registered)
//   in_Ctrl .. in_RegWrite  decoded operation and register-file read data
//   Mem*/Wb*             MEM and WB writeback candidates used for forwarding
//   out_valid / out_ready   ALU-side handshake
//   Ctrl, SrcA, SrcB     ALU operation and operands
//   out_Rd, out_RegWrite destination information passed downstream
// ---------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_Ctrl,
  input  logic [RADDR-1:0] in_Rs1,
  input  logic [RADDR-1:0] in_Rs2,
  input  logic [XLEN-1:0]  in_RD1,
  input  logic [XLEN-1:0]  in_RD2,
  input  logic [XLEN-1:0]  in_Imm,
  input  logic             in_ALUSrc,
  input  logic [RADDR-1:0] in_Rd,
  input  logic             in_RegWrite,
  input  logic             MemRegWrite,
  input  logic [RADDR-1:0] MemRd,
  input  logic [XLEN-1:0]  MemResult,
  input  logic             WbRegWrite,
  input  logic [RADDR-1:0] WbRd,
  input  logic [XLEN-1:0]  WbResult,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       Ctrl,
  output logic [XLEN-1:0]  SrcA,
  output logic [XLEN-1:0]  SrcB,
  output logic [RADDR-1:0] out_Rd,
  output logic             out_RegWrite
);

  // One held operation. The source indices are kept so that a waiting entry
  // can still pick up results that retire while it sits here.
  typedef struct packed {
    logic             valid;
    logic [2:0]       ctrl;
    logic [RADDR-1:0] rs1;
    logic [RADDR-1:0] rs2;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [XLEN-1:0]  imm;
    logic             aluSrc;
    logic [RADDR-1:0] rd;
    logic             regWrite;
  } entry_t;

  entry_t r_main;
  entry_t r_skid;
  logic   r_inReady;

  entry_t w_inEntry;
  entry_t w_mainSnoop;
  entry_t w_skidSnoop;
  entry_t w_mainNext;
  entry_t w_skidNext;
  logic   w_accept;
  logic   w_drain;

`ifdef ALU_ISSUE_FWD_EN
  // Newest producer wins: MEM holds a younger result than WB. Index 0 is the
  // hard-wired zero register and never takes a forwarded value.
  function automatic logic [XLEN-1:0] fwdValue(
    input logic [RADDR-1:0] idx,
    input logic [XLEN-1:0]  dflt,
    input logic             memWe,
    input logic [RADDR-1:0] memIdx,
    input logic [XLEN-1:0]  memVal,
    input logic             wbWe,
    input logic [RADDR-1:0] wbIdx,
    input logic [XLEN-1:0]  wbVal
  );
    if (idx == '0)
      return '0;
    else if (memWe && (memIdx == idx))
      return memVal;
    else if (wbWe && (wbIdx == idx))
      return wbVal;
    else
      return dflt;
  endfunction
`else
  // MEM/WB ports exist only so both builds share one port list.
  logic w_unusedFwd;
  assign w_unusedFwd = ^{MemRegWrite, MemRd, MemResult, WbRegWrite, WbRd, WbResult};
`endif

  assign w_accept = in_valid & r_inReady;
  assign w_drain  = r_main.valid & out_ready;

  // Build the entry for the operation being offered, with its operands
  // already resolved against the in-flight writebacks.
  always_comb begin
    w_inEntry          = '0;
    w_inEntry.valid    = 1'b1;
    w_inEntry.ctrl     = in_Ctrl;
    w_inEntry.rs1      = in_Rs1;
    w_inEntry.rs2      = in_Rs2;
    w_inEntry.imm      = in_Imm;
    w_inEntry.aluSrc   = in_ALUSrc;
    w_inEntry.rd       = in_Rd;
    w_inEntry.regWrite = in_RegWrite;
`ifdef ALU_ISSUE_FWD_EN
    w_inEntry.a = fwdValue(in_Rs1, in_RD1, MemRegWrite, MemRd, MemResult,
                           WbRegWrite, WbRd, WbResult);
    w_inEntry.b = fwdValue(in_Rs2, in_RD2, MemRegWrite, MemRd, MemResult,
                           WbRegWrite, WbRd, WbResult);
`else
    w_inEntry.a = (in_Rs1 == '0) ? '0 : in_RD1;
    w_inEntry.b = (in_Rs2 == '0) ? '0 : in_RD2;
`endif
  end

  // Held entries watch the writeback buses every cycle so that an operand
  // captured before its producer retired is still correct when issued.
  // The skid copy is snooped too, so a skid-to-main move carries fresh data.
  always_comb begin
    w_mainSnoop = r_main;
    w_skidSnoop = r_skid;
`ifdef ALU_ISSUE_FWD_EN
    if (r_main.valid) begin
      w_mainSnoop.a = fwdValue(r_main.rs1, r_main.a, MemRegWrite, MemRd, MemResult,
                               WbRegWrite, WbRd, WbResult);
      w_mainSnoop.b = fwdValue(r_main.rs2, r_main.b, MemRegWrite, MemRd, MemResult,
                               WbRegWrite, WbRd, WbResult);
    end
    if (r_skid.valid) begin
      w_skidSnoop.a = fwdValue(r_skid.rs1, r_skid.a, MemRegWrite, MemRd, MemResult,
                               WbRegWrite, WbRd, WbResult);
      w_skidSnoop.b = fwdValue(r_skid.rs2, r_skid.b, MemRegWrite, MemRd, MemResult,
                               WbRegWrite, WbRd, WbResult);
    end
`endif
  end

  // Entry movement. in_ready is only high while the skid is empty, so an
  // accept never collides with a skid-to-main move. When main is free the
  // older skid entry always goes first to keep strict FIFO order.
  always_comb begin
    w_mainNext = w_mainSnoop;
    w_skidNext = w_skidSnoop;
    if (!r_main.valid || w_drain) begin
      if (r_skid.valid) begin
        w_mainNext       = w_skidSnoop;
        w_skidNext.valid = 1'b0;
      end else if (w_accept) begin
        w_mainNext = w_inEntry;
      end else begin
        w_mainNext.valid = 1'b0;
      end
    end else if (w_accept) begin
      w_skidNext = w_inEntry;
    end
  end

  // State register. Reset clears contents as well so the ALU sees zeros;
  // flush only drops validity, which is enough to suppress the operations.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_main    <= '0;
      r_skid    <= '0;
      r_inReady <= 1'b1;
    end else if (flush) begin
      r_main.valid <= 1'b0;
      r_skid.valid <= 1'b0;
      r_inReady    <= 1'b1;
    end else begin
      r_main    <= w_mainNext;
      r_skid    <= w_skidNext;
      r_inReady <= ~w_skidNext.valid;
    end
  end

  assign in_ready     = r_inReady;
  assign out_valid    = r_main.valid;
  assign Ctrl         = r_main.ctrl;
  assign SrcA         = r_main.a;
  assign SrcB         = r_main.aluSrc ? r_main.imm : r_main.b;
  assign out_Rd       = r_main.rd;
  assign out_RegWrite = r_main.regWrite;

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Drives alu_issue_stage with directed scenarios followed by randomized
// traffic, and compares it each cycle against a queue-based reference model
// holding up to two pending operations in arrival order. Honors the
// ALU_ISSUE_FWD_EN macro in the same way as the design.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready;
  logic [2:0]  in_Ctrl;
  logic [4:0]  in_Rs1, in_Rs2, in_Rd;
  logic [31:0] in_RD1, in_RD2, in_Imm;
  logic        in_ALUSrc, in_RegWrite;
  logic        MemRegWrite, WbRegWrite;
  logic [4:0]  MemRd, WbRd;
  logic [31:0] MemResult, WbResult;
  logic        out_valid, out_ready;
  logic [2:0]  Ctrl;
  logic [31:0] SrcA, SrcB;
  logic [4:0]  out_Rd;
  logic        out_RegWrite;

  typedef struct {
    logic [2:0]  ctrl;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] a, b, imm;
    logic        aluSrc, regWrite;
  } op_t;

  op_t pending[$];
  int  checks = 0;
  int  errors = 0;

  alu_issue_stage #(.XLEN(32), .RADDR(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_Ctrl(in_Ctrl), .in_Rs1(in_Rs1), .in_Rs2(in_Rs2),
    .in_RD1(in_RD1), .in_RD2(in_RD2), .in_Imm(in_Imm),
    .in_ALUSrc(in_ALUSrc), .in_Rd(in_Rd), .in_RegWrite(in_RegWrite),
    .MemRegWrite(MemRegWrite), .MemRd(MemRd), .MemResult(MemResult),
    .WbRegWrite(WbRegWrite), .WbRd(WbRd), .WbResult(WbResult),
    .out_valid(out_valid), .out_ready(out_ready),
    .Ctrl(Ctrl), .SrcA(SrcA), .SrcB(SrcB),
    .out_Rd(out_Rd), .out_RegWrite(out_RegWrite)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", tag, observed, expected);
    end
  endtask

  // Value a register index should read given the writebacks visible now.
  function automatic logic [31:0] refValue(input logic [4:0] r, input logic [31:0] dflt);
    if (r == 5'd0) return 32'd0;
`ifdef ALU_ISSUE_FWD_EN
    if (MemRegWrite && MemRd == r) return MemResult;
    if (WbRegWrite && WbRd == r) return WbResult;
`endif
    return dflt;
  endfunction

  // Advance the reference model by one clock edge using the inputs that
  // were present at that edge.
  task automatic modelStep();
    op_t n;
    bit  acc, drn;
    acc = in_valid && (pending.size() < 2);
    drn = out_ready && (pending.size() > 0);
    if (reset || flush) begin
      pending.delete();
    end else begin
      foreach (pending[i]) begin
        pending[i].a = refValue(pending[i].rs1, pending[i].a);
        pending[i].b = refValue(pending[i].rs2, pending[i].b);
      end
      if (drn) void'(pending.pop_front());
      if (acc) begin
        n.ctrl = in_Ctrl;  n.rs1 = in_Rs1;  n.rs2 = in_Rs2;  n.rd = in_Rd;
        n.a = refValue(in_Rs1, in_RD1);
        n.b = refValue(in_Rs2, in_RD2);
        n.imm = in_Imm;  n.aluSrc = in_ALUSrc;  n.regWrite = in_RegWrite;
        pending.push_back(n);
      end
    end
  endtask

  // Compare every visible output against the head of the model queue.
  task automatic checkModel();
    checkOutput("out_valid", {31'd0, out_valid}, {31'd0, pending.size() > 0});
    checkOutput("in_ready", {31'd0, in_ready}, {31'd0, pending.size() < 2});
    if (pending.size() > 0) begin
      checkOutput("Ctrl", {29'd0, Ctrl}, {29'd0, pending[0].ctrl});
      checkOutput("SrcA", SrcA, pending[0].a);
      checkOutput("SrcB", SrcB, pending[0].aluSrc ? pending[0].imm : pending[0].b);
      checkOutput("out_Rd", {27'd0, out_Rd}, {27'd0, pending[0].rd});
      checkOutput("out_RegWrite", {31'd0, out_RegWrite}, {31'd0, pending[0].regWrite});
    end
  endtask

  task automatic runCycle();
    @(posedge clk);
    modelStep();
    @(negedge clk);
    checkModel();
  endtask

  task automatic setIdle();
    reset = 1'b0;  flush = 1'b0;  in_valid = 1'b0;  out_ready = 1'b1;
    MemRegWrite = 1'b0;  WbRegWrite = 1'b0;
    MemRd = 5'd0;  WbRd = 5'd0;  MemResult = 32'd0;  WbResult = 32'd0;
  endtask

  task automatic setOp(input logic [2:0] c, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [31:0] d1, input logic [31:0] d2,
                       input logic [31:0] imm, input logic src);
    in_valid = 1'b1;  in_Ctrl = c;  in_Rs1 = r1;  in_Rs2 = r2;
    in_RD1 = d1;  in_RD2 = d2;  in_Imm = imm;  in_ALUSrc = src;
    in_Rd = 5'($urandom_range(0, 31));  in_RegWrite = 1'($urandom);
  endtask

  // Random traffic with small register indices so hazards are frequent.
  task automatic applyStimulus(input int cyc);
    reset = ($urandom_range(0, 199) == 0);
    flush = ($urandom_range(0, 39) == 0);
    in_valid = ($urandom_range(0, 3) != 0);
    out_ready = ((cyc / 64) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                      : ($urandom_range(0, 3) == 0);
    in_Ctrl = 3'($urandom);  in_Rs1 = 5'($urandom_range(0, 3));
    in_Rs2 = 5'($urandom_range(0, 3));  in_Rd = 5'($urandom);
    in_RD1 = $urandom;  in_RD2 = $urandom;  in_Imm = $urandom;
    in_ALUSrc = 1'($urandom);  in_RegWrite = 1'($urandom);
    MemRegWrite = 1'($urandom);  MemRd = 5'($urandom_range(0, 3));
    MemResult = $urandom;
    WbRegWrite = 1'($urandom);  WbRd = 5'($urandom_range(0, 3));
    WbResult = $urandom;
  endtask

  initial begin
    setIdle();
    setOp(3'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    runCycle();
    runCycle();
    reset = 1'b0;
    runCycle();
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset Ctrl", {29'd0, Ctrl}, 32'd0);
    checkOutput("reset SrcA", SrcA, 32'd0);
    checkOutput("reset SrcB", SrcB, 32'd0);
    checkOutput("reset out_Rd", {27'd0, out_Rd}, 32'd0);
    checkOutput("reset out_RegWrite", {31'd0, out_RegWrite}, 32'd0);

    // Single op held so it can be inspected.
    out_ready = 1'b0;
    setOp(3'd0, 5'd1, 5'd2, 32'd5, 32'd7, 32'h1234, 1'b0);
    runCycle();
    in_valid = 1'b0;
    checkOutput("single out_valid", {31'd0, out_valid}, 32'd1);
    checkOutput("single SrcA", SrcA, 32'd5);
    checkOutput("single SrcB", SrcB, 32'd7);
    out_ready = 1'b1;
    runCycle();

    // Immediate operand selection.
    out_ready = 1'b0;
    setOp(3'd1, 5'd1, 5'd2, 32'd3, 32'd9, 32'hFFFF_FFFC, 1'b1);
    runCycle();
    in_valid = 1'b0;
    checkOutput("imm SrcB", SrcB, 32'hFFFF_FFFC);
    out_ready = 1'b1;
    runCycle();

    // MEM beats WB; x0 is never forwarded.
    MemRegWrite = 1'b1;  MemRd = 5'd3;  MemResult = 32'h10;
    WbRegWrite = 1'b1;   WbRd = 5'd3;   WbResult = 32'h20;
    setOp(3'd2, 5'd3, 5'd1, 32'd1, 32'd2, 32'd0, 1'b0);
    runCycle();
`ifdef ALU_ISSUE_FWD_EN
    checkOutput("fwd priority SrcA", SrcA, 32'h10);
`else
    checkOutput("fwd priority SrcA", SrcA, 32'h1);
`endif
    MemRd = 5'd0;  WbRd = 5'd0;
    setOp(3'd3, 5'd0, 5'd1, 32'd1, 32'd2, 32'd0, 1'b0);
    runCycle();
    checkOutput("x0 SrcA", SrcA, 32'd0);
    setIdle();
    runCycle();

    // Backpressure: two accepted, then in_ready drops.
    out_ready = 1'b0;
    setOp(3'd0, 5'd1, 5'd2, 32'hA1, 32'hA2, 32'd0, 1'b0);
    runCycle();
    setOp(3'd1, 5'd1, 5'd2, 32'hB1, 32'hB2, 32'd0, 1'b0);
    runCycle();
    checkOutput("stall in_ready", {31'd0, in_ready}, 32'd0);
    setOp(3'd2, 5'd1, 5'd2, 32'hC1, 32'hC2, 32'd0, 1'b0);
    runCycle();
    out_ready = 1'b1;
    runCycle();
    runCycle();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) runCycle();

    // Snoop while stalled.
    out_ready = 1'b0;
    setOp(3'd0, 5'd1, 5'd4, 32'd0, 32'h11, 32'd0, 1'b0);
    runCycle();
    in_valid = 1'b0;
    WbRegWrite = 1'b1;  WbRd = 5'd4;  WbResult = 32'hAB;
    runCycle();
`ifdef ALU_ISSUE_FWD_EN
    checkOutput("snoop SrcB", SrcB, 32'hAB);
`else
    checkOutput("snoop SrcB", SrcB, 32'h11);
`endif
    setIdle();
    runCycle();

    // Flush with both entries full and a same-cycle offer.
    out_ready = 1'b0;
    setOp(3'd0, 5'd1, 5'd2, 32'hD1, 32'hD2, 32'd0, 1'b0);
    runCycle();
    setOp(3'd1, 5'd1, 5'd2, 32'hE1, 32'hE2, 32'd0, 1'b0);
    runCycle();
    setOp(3'd2, 5'd1, 5'd2, 32'hF1, 32'hF2, 32'd0, 1'b0);
    flush = 1'b1;
    runCycle();
    checkOutput("flush out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("flush in_ready", {31'd0, in_ready}, 32'd1);
    setIdle();
    for (int i = 0; i < 3; i++) runCycle();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      applyStimulus(cyc);
      runCycle();
    end

    setIdle();
    for (int i = 0; i < 4; i++) runCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Execute-issue pipeline stage sitting directly upstream of the RISC-V ALU. It captures decoded operations from the decode stage and resolves operand hazards by forwarding from the MEM and WB stages. It presents registered `Ctrl`/`SrcA`/`SrcB` to the ALU through a valid/ready handshake. A two-entry skid buffer gives full throughput with a registered `in_ready`.

## Interface
- `XLEN`, 32: datapath width.
- `RADDR`, 5: register index width.

- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  discard all held entries (branch redirect).
- `in_valid`  in  1  decode offers an operation.
- `in_ready`  out  1  stage accepts; registered.
- `in_Ctrl`  in  3  ALU operation code (000 add, 001 sub, 010 and, 011 or, 101 slt).
- `in_Rs1`, `in_Rs2`  in  RADDR  source register indices.
- `in_RD1`, `in_RD2`  in  XLEN  register-file read data.
- `in_Imm`  in  XLEN  sign-extended immediate.
- `in_ALUSrc`  in  1  1: SrcB = immediate; 0: SrcB = rs2 value.
- `in_Rd`  in  RADDR  destination index.
- `in_RegWrite`  in  1  destination is written.
- `MemRegWrite`, `MemRd`, `MemResult`  in  1/RADDR/XLEN  MEM-stage writeback candidate.
- `WbRegWrite`, `WbRd`, `WbResult`  in  1/RADDR/XLEN  WB-stage writeback candidate.
- `out_valid`  out  1  ALU operands valid.
- `out_ready`  in  1  downstream consumes.
- `Ctrl`  out  3  to ALU.
- `SrcA`, `SrcB`  out  XLEN  to ALU.
- `out_Rd`  out  RADDR  destination index forwarded downstream.
- `out_RegWrite`  out  1  forwarded downstream.

## Operation
- Storage: main entry (drives outputs) and skid entry. Each entry holds a valid bit, Ctrl, Rs1, Rs2, A value, B value, Imm, ALUSrc, Rd, and RegWrite.
- Accept = `in_valid & in_ready`. Drain = `out_valid & out_ready`.
- `in_ready` next = !(skid valid next). Reset value is 1.
- Accept into main if main is empty or drains this cycle and the skid is empty. Otherwise accept into the skid.
- On drain with skid valid: skid moves to main and the skid empties.
- Forward select per operand with index r, applied to incoming values at accept:
  - r == 0: value 0.
  - Else if MemRegWrite & MemRd == r: MemResult.
  - Else if WbRegWrite & WbRd == r: WbResult.
  - Else: the register-file value.
- Snoop: every cycle, each held valid entry (main and skid) updates its A and B values when MEM or WB writes a matching nonzero index. MEM wins over WB. An entry moving skid to main carries its snooped value.
- Output mapping: `SrcA` = main A value. `SrcB` = main ALUSrc ? main Imm : main B value.
- `flush`: both valid bits clear next cycle. A same-cycle accept is discarded. `in_ready` returns to 1 next cycle.
- Simultaneous `flush` and `reset`: reset behaviour.
- Ordering is strictly FIFO. No entry is dropped or duplicated except by flush or reset.

## Timing
- Latency: accept at edge N produces `out_valid` high after edge N, so it is visible in cycle N+1.
- Throughput: 1 operation per cycle while `out_ready` is held high.
- Stall: `out_ready` low with main full. One more accept lands in the skid, then `in_ready` drops the following cycle.
- Outputs hold stable while `out_valid & !out_ready`, except operand values updated by snoop.
- Reset values: `out_valid` 0, `in_ready` 1, `Ctrl` 000, `SrcA` 0, `SrcB` 0, `out_Rd` 0, `out_RegWrite` 0. All skid contents are 0.
- Reset mid-stall: both entries are lost. Outputs take reset values after the reset edge.

## Configuration
- `ALU_ISSUE_FWD_EN` defined: forwarding and snoop are active as described.
- `ALU_ISSUE_FWD_EN` undefined: register-file values are captured unchanged (x0 still forced to 0). There is no snoop. MEM/WB inputs are ignored and the forwarding mux logic is absent.

## Test plan
- Reset then single op: Ctrl=000, RD1=5, RD2=7, ALUSrc=0 → cycle after accept `out_valid`=1, SrcA=5, SrcB=7. After reset release, `in_ready`=1.
- Immediate: ALUSrc=1, Imm=0xFFFFFFFC, RD2=9 → SrcB=0xFFFFFFFC.
- Forward priority: Rs1=3, RD1=1, MemRd=3/MemResult=0x10, WbRd=3/WbResult=0x20, both write enables high → SrcA=0x10. Rs1=0 with the same stimulus → SrcA=0.
- Backpressure: out_ready=0, 3 back-to-back ops → first two accepted, `in_ready`=0 from the cycle after the second. Releasing out_ready yields ops in order, one per cycle.
- Snoop while stalled: main Rs2=4 stalled, WbRegWrite=1, WbRd=4, WbResult=0xAB → next cycle SrcB=0xAB. With the macro undefined → SrcB unchanged.
- Flush with both entries full plus same-cycle in_valid → next cycle `out_valid`=0, `in_ready`=1, and no flushed op ever appears on the outputs.
